atan_arg_reduce: RTL
====================

# atan_arg_reduce

Argument-reduction front end of the atan polynomial datapath. Accepts a signed (x, y) vector and folds it into the first octant. Produces the unsigned ratio r = min(|x|,|y|)/max(|x|,|y|) in Q0.16 using a 16-iteration restoring divider, then registers r² as `atan_poly_pow_2`, the operand consumed directly by the constant-A multiplier stage. Octant flags travel with the result so the downstream reconstruction stage can unfold the angle.

## Interface
Parameters: none. Widths are fixed by the package constants.

- `clk` input 1 — single clock, rising edge.
- `rst_n` input 1 — synchronous, active-low reset.
- `in_valid` input 1 — input vector valid.
- `in_ready` output 1 — block can accept a vector.
- `in_x` input 16 — signed two's-complement x.
- `in_y` input 16 — signed two's-complement y.
- `out_valid` output 1 — result valid.
- `out_ready` input 1 — downstream accepts the result.
- `atan_poly_ratio` output 16 — r, unsigned Q0.16.
- `atan_poly_pow_2` output 16 — r², unsigned Q0.16 (feeds multiplier operand A).
- `oct_swap` output 1 — 1 when |y| > |x|.
- `x_neg` output 1 — sign bit of captured x.
- `y_neg` output 1 — sign bit of captured y.

## Operation
- FSM states: IDLE → ABS → DIV → SQR → DONE → IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: capture `in_x`/`in_y`, go to ABS.
- ABS:
  - |x| and |y| as 16-bit unsigned; |−32768| = 32768, no overflow.
  - num = min, den = max.
  - `oct_swap` = (|y| > |x|); equal magnitudes give 0.
  - `x_neg`/`y_neg` = sign bits of the captured operands.
- DIV:
  - Restoring division of num·2¹⁶ by den, one quotient bit per cycle, MSB first.
  - Exactly 16 cycles, counted by a 4-bit counter.
  - Remainder register is 17 bits.
- Special cases, resolved in ABS; the DIV cycles still elapse so latency is constant:
  - den = 0 (x = y = 0): r = 0.
  - num = den ≠ 0: r saturates to 0xFFFF, since 1.0 is not representable.
- SQR: `atan_poly_pow_2` = (r·r)[31:16] from a 32-bit unsigned product, truncated (no rounding).
- DONE:
  - `out_valid`=1; all outputs held stable while `out_ready`=0.
  - On `out_ready`: go to IDLE.
- `rst_n`=0 at any state, including mid-DIV:
  - Next edge forces IDLE, counter cleared, partial quotient discarded.
  - No output is produced for an aborted vector.

## Timing
- Reset values: `in_ready`=0 during reset and 1 in the first cycle after release. `out_valid`=0. `atan_poly_ratio`=0, `atan_poly_pow_2`=0, `oct_swap`=0, `x_neg`=0, `y_neg`=0.
- Accept edge t (`in_valid`&&`in_ready`) → `out_valid` first high in the cycle after edge t+18. Fixed latency of 19 cycles.
- `in_ready` is high only in IDLE. No input is accepted while a vector is in flight.
- Minimum initiation interval is 20 cycles (DONE handshake edge, then IDLE for one cycle).
- `in_valid` deasserting in IDLE without a handshake is legal and has no effect.
- Data outputs change only on the edge entering DONE.

## Structure
- Shared package `atan_pkg`:
  - `ATAN_W`=16 and `ATAN_PROD_W`=32.
  - `DIV_ITER`=16.
  - State enum `arg_state_t`.
  - `RATIO_SAT`=16'hFFFF.
  - The multiplier product width 23, so neighbouring stages share one source.
- Sub-module `atan_ratio_div`: the sequential restoring divider with start/done pulses, kept separate for reuse and unit test.
- Top-level FSM, abs/compare logic and squaring register stay in `atan_arg_reduce`.

## Test plan
- x=16384, y=8192 → r=0x8000, pow_2=0x4000, oct_swap=0, x_neg=0, y_neg=0, `out_valid` exactly 19 cycles after accept.
- x=−8192, y=16384 → r=0x8000, pow_2=0x4000, oct_swap=1, x_neg=1, y_neg=0.
- x=1000, y=1000 → r=0xFFFF, pow_2=0xFFFE, oct_swap=0. Then x=y=0 → r=0, pow_2=0.
- x=−32768, y=−1 → r=0x0002, pow_2=0x0000, x_neg=1, y_neg=1.
- x=3, y=1, `out_ready` held low for 10 cycles:
  - Outputs stable with r=0x5555 and pow_2=0x1C71.
  - `in_ready`=0 throughout.
  - One cycle after release, `in_ready`=1.
- `rst_n` pulsed low at DIV iteration 7 → IDLE next cycle, no `out_valid`. A new vector then completes correctly with full 19-cycle latency.

Source files
------------

// File: rtl/atan_pkg.sv
// Shared widths, states and helpers for the atan datapath.
// Neighbouring stages import this so widths stay in one place.
package atan_pkg;

  localparam int ATAN_W      = 16;
  localparam int ATAN_PROD_W = 32;
  localparam int ATAN_MUL_W  = 23;
  localparam int DIV_ITER    = 16;
  localparam int CNT_W       = 4;

  localparam logic [ATAN_W-1:0] RATIO_SAT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABS,
    ST_DIV,
    ST_SQR,
    ST_DONE
  } arg_state_t;

  // Magnitude of a two's-complement word; 0x8000 maps to 32768.
  function automatic logic [ATAN_W-1:0] mag(
    input logic [ATAN_W-1:0] v
  );
    return v[ATAN_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/atan_arg_reduce_if.sv
// Handshake bundle between the vector source, the argument
// reducer and the polynomial stage that consumes r and r^2.
interface atan_arg_reduce_if;
  import atan_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ATAN_W-1:0] in_x;
  logic [ATAN_W-1:0] in_y;
  logic              out_valid;
  logic              out_ready;
  logic [ATAN_W-1:0] atan_poly_ratio;
  logic [ATAN_W-1:0] atan_poly_pow_2;
  logic              oct_swap;
  logic              x_neg;
  logic              y_neg;

  modport master (
    output in_valid, in_x, in_y, out_ready,
    input  in_ready, out_valid,
    input  atan_poly_ratio, atan_poly_pow_2,
    input  oct_swap, x_neg, y_neg
  );

  modport slave (
    input  in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid,
    output atan_poly_ratio, atan_poly_pow_2,
    output oct_swap, x_neg, y_neg
  );

endinterface

// File: rtl/atan_ratio_div.sv
// Sequential restoring divider: quo = floor(num*2^16/den).
// Needs num < den; done_o flags the final iteration cycle.
module atan_ratio_div
  import atan_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ATAN_W-1:0] num_i,
  input  logic [ATAN_W-1:0] den_i,
  output logic              done_o,
  output logic [ATAN_W-1:0] quo_o
);

  logic [ATAN_W:0]   rem_q, rem_d;
  logic [ATAN_W-1:0] den_q, den_d;
  logic [ATAN_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [ATAN_W:0]   shl;
  logic              ge;

  assign shl = rem_q << 1;
  assign ge  = shl >= {1'b0, den_q};

  // Load on start, then one quotient bit per cycle, MSB first.
  always_comb begin
    rem_d  = rem_q;
    den_d  = den_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      rem_d  = {1'b0, num_i};
      den_d  = den_i;
      quo_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = ge ? (shl - {1'b0, den_q}) : shl;
      quo_d = {quo_q[ATAN_W-2:0], ge};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(DIV_ITER - 1))
        busy_d = 1'b0;
    end
  end

  // Divider state; reset drops any partial quotient.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      den_q  <= den_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done_o = busy_q && (cnt_q == CNT_W'(DIV_ITER - 1));
  assign quo_o  = quo_q;

endmodule

// File: rtl/atan_arg_reduce.sv
// Folds (x, y) into the first octant and produces r and r^2
// with octant flags for the reconstruction stage.
module atan_arg_reduce
  import atan_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  atan_arg_reduce_if.slave   bus
);

  arg_state_t        state_q, state_d;
  logic [ATAN_W-1:0] x_q, y_q;
  logic              swap_q, sat_q, zero_q;
  logic [ATAN_W-1:0] ratio_q, pow_q;
  logic              oswap_q, oxn_q, oyn_q;

  logic [ATAN_W-1:0] ax, ay, num, den, quo, r;
  logic              start, div_done;
  logic              accept;

  assign accept = (state_q == ST_IDLE) && bus.in_valid;
  assign ax     = mag(x_q);
  assign ay     = mag(y_q);
  assign num    = (ay > ax) ? ax : ay;
  assign den    = (ay > ax) ? ay : ax;

  atan_ratio_div u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .num_i   (num),
    .den_i   (den),
    .done_o  (div_done),
    .quo_o   (quo)
  );

  assign r = zero_q ? '0 : (sat_q ? RATIO_SAT : quo);

  // Next state and the single-cycle divider start strobe.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (bus.in_valid) state_d = ST_ABS;
      ST_ABS: begin
        start   = 1'b1;
        state_d = ST_DIV;
      end
      ST_DIV:  if (div_done) state_d = ST_SQR;
      ST_SQR:  state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture the operand pair on the accepting edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (accept) begin
      x_q <= bus.in_x;
      y_q <= bus.in_y;
    end
  end

  // Resolve octant and special cases while the divider loads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      swap_q <= 1'b0;
      sat_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (state_q == ST_ABS) begin
      swap_q <= ay > ax;
      sat_q  <= (num == den) && (den != '0);
      zero_q <= den == '0;
    end
  end

  // Outputs only move on the edge into DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ratio_q <= '0;
      pow_q   <= '0;
      oswap_q <= 1'b0;
      oxn_q   <= 1'b0;
      oyn_q   <= 1'b0;
    end else if (state_q == ST_SQR) begin
      ratio_q <= r;
      pow_q   <= ATAN_W'(({{ATAN_W{1'b0}}, r} *
                          {{ATAN_W{1'b0}}, r}) >> ATAN_W);
      oswap_q <= swap_q;
      oxn_q   <= x_q[ATAN_W-1];
      oyn_q   <= y_q[ATAN_W-1];
    end
  end

  assign bus.in_ready        = rst_n && (state_q == ST_IDLE);
  assign bus.out_valid       = state_q == ST_DONE;
  assign bus.atan_poly_ratio = ratio_q;
  assign bus.atan_poly_pow_2 = pow_q;
  assign bus.oct_swap        = oswap_q;
  assign bus.x_neg           = oxn_q;
  assign bus.y_neg           = oyn_q;

endmodule
